fast_core_onchip_data_mem: RTL and testbench
============================================

Name: fast_core_onchip_data_mem

Overview:
- Parametrised on-chip data memory for the FP51 fast core: IRAM, upper IRAM, XRAM and the SFR window behind one decoder.
- Adds over the previous generation:
  - configurable read latency and XRAM depth;
  - 8052-style upper IRAM, reached by indirect/stack access to 0x80-0xFF;
  - a second DMA port with core-priority arbitration and starvation relief;
  - sticky out-of-range error detection.
- Sits between the core datapath and the SFR block.

Parameters:
- ADDR_WIDTH, 16, core/DMA address width.
- DATA_WIDTH, 8, data width.
- XRAM_DEPTH, 1024, XRAM bytes, mapped at 0x100 .. 0x100+XRAM_DEPTH-1.
- READ_LATENCY, 1, cycles from rd_en to rd_valid; legal values 1..3.
- STARVE_LIMIT, 8, consecutive denied DMA cycles before a core stall is forced; legal values 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- rd_en  in  1  core read request.
- rd_addr  in  ADDR_WIDTH  core read address.
- rd_indirect  in  1  1 = indirect/stack read: 0x80-0xFF goes to upper IRAM, not SFR.
- wr_en  in  1  core write request.
- wr_addr  in  ADDR_WIDTH  core write address.
- wr_data  in  DATA_WIDTH  core write data.
- wr_indirect  in  1  as rd_indirect, for writes.
- rd_data  out  DATA_WIDTH  core read data.
- rd_valid  out  1  rd_data valid.
- core_stall  out  1  core must hold its request this cycle.
- sfr_rd  out  1  direct read of 0x80-0xFF.
- sfr_rdata  in  DATA_WIDTH  SFR read data, valid one cycle after sfr_rd.
- sfr_we  out  1  direct write of 0x80-0xFF.
- sfr_addr  out  8  SFR address: write address when sfr_we, else read address.
- sfr_wdata  out  DATA_WIDTH  SFR write data.
- dma_req  in  1  DMA request.
- dma_we  in  1  1 = DMA write, 0 = DMA read.
- dma_addr  in  ADDR_WIDTH  DMA address; always decoded as indirect, never SFR.
- dma_wdata  in  DATA_WIDTH  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rdata  out  DATA_WIDTH  DMA read data.
- dma_rvalid  out  1  dma_rdata valid.
- addr_err  out  1  sticky out-of-range flag.
- err_clr  in  1  clears addr_err.

Behaviour:
- Decode, per access:
  - 0x00-0x7F: IRAM.
  - 0x80-0xFF indirect: upper IRAM.
  - 0x80-0xFF direct: SFR.
  - 0x100 .. 0x100+XRAM_DEPTH-1: XRAM.
  - Anything above: out-of-range.
- Memory is write-first.
- A core read issued in cycle t returns, at t+READ_LATENCY with rd_valid=1, the latest write to that address issued in cycle ≤ t:
  - a same-cycle write (core or DMA) is bypassed;
  - writes in cycles t+1 .. t+READ_LATENCY do not affect the result.
- SFR reads are aligned to the same latency: sfr_rdata is captured one cycle after sfr_rd, then delayed READ_LATENCY-1 cycles.
- A direct core write to the SFR window does not bypass to a same-cycle direct read; the SFR block owns that value.
- sfr_we = wr_en & direct & addr in 0x80-0xFF & ~core_stall. This output is combinational.
- Out-of-range access:
  - writes are dropped;
  - reads return all-ones with normal valid timing;
  - addr_err is set the following cycle;
  - err_clr clears addr_err; if a set and err_clr occur together, set wins.
- Arbitration:
  - The core has priority.
  - A DMA read is granted when rd_en=0; a DMA write is granted when wr_en=0.
  - dma_gnt is combinational in the accept cycle.
  - dma_rdata/dma_rvalid follow READ_LATENCY, with the same forwarding rule as core reads.
- Starvation counter:
  - Increments on each cycle with dma_req=1 & dma_gnt=0.
  - Clears on grant or when dma_req=0.
  - When it reaches STARVE_LIMIT, core_stall=1 for exactly one cycle. In that cycle core requests are ignored (no memory, SFR or rd_valid effect), the DMA is granted, and the counter clears.
- Reset:
  - All outputs go to 0, the counter clears and in-flight reads are discarded (no rd_valid or dma_rvalid after reset).
  - Memory contents are not initialised.
  - Reset asserted mid-pipeline kills pending valids immediately.

Test Plan:
- Write 0x5A to 0x30 at t, read 0x30 at t (same cycle) -> rd_data=0x5A at t+READ_LATENCY; a write of 0x11 at t+1 does not alter it. Run with READ_LATENCY=1 and 3.
- Direct write 0x90 <- 0x22 -> sfr_we=1, sfr_addr=0x90. Indirect write 0x90 <- 0x33 -> sfr_we=0. Indirect read 0x90 -> 0x33. Direct read 0x90 with sfr_rdata=0x44 -> 0x44.
- XRAM_DEPTH=1024: write 0x4FF <- 0xA5, then read it back -> 0xA5. Read 0x500 -> 0xFF and addr_err=1 next cycle; err_clr -> 0; simultaneous out-of-range and err_clr -> stays 1.
- Core reads and writes every cycle while dma_req=1, STARVE_LIMIT=8 -> dma_gnt=0 for 8 cycles, then core_stall=1 with dma_gnt=1 in the same cycle; the core request in that cycle has no effect.
- DMA writes 0x77 to 0x200 while the core has rd_en=0 and wr_en=1 on a different address -> a DMA write is not granted in that cycle. Repeat with wr_en=0 -> granted; a core read of 0x200 in the same cycle returns 0x77.
- Assert reset with 2 reads in flight (READ_LATENCY=3) -> rd_valid stays 0, addr_err=0, core_stall=0.

Source files
------------

// File: rtl/fast_core_onchip_data_mem_if.sv
// Bus bundle for the FP51 fast-core data memory: core read/write ports,
// SFR window handshake, DMA port and error flag.
interface fast_core_onchip_data_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_indirect;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_indirect;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  core_stall;
  logic                  sfr_rd;
  logic [DATA_WIDTH-1:0] sfr_rdata;
  logic                  sfr_we;
  logic [7:0]            sfr_addr;
  logic [DATA_WIDTH-1:0] sfr_wdata;
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_rvalid;
  logic                  addr_err;
  logic                  err_clr;

  // Memory side
  modport slave (
    input  rd_en, rd_addr, rd_indirect, wr_en, wr_addr, wr_data, wr_indirect,
    input  sfr_rdata, dma_req, dma_we, dma_addr, dma_wdata, err_clr,
    output rd_data, rd_valid, core_stall, sfr_rd, sfr_we, sfr_addr, sfr_wdata,
    output dma_gnt, dma_rdata, dma_rvalid, addr_err
  );

  // Core / DMA / SFR-block side
  modport master (
    output rd_en, rd_addr, rd_indirect, wr_en, wr_addr, wr_data, wr_indirect,
    output sfr_rdata, dma_req, dma_we, dma_addr, dma_wdata, err_clr,
    input  rd_data, rd_valid, core_stall, sfr_rd, sfr_we, sfr_addr, sfr_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid, addr_err
  );
endinterface

// File: rtl/fast_core_onchip_data_mem.sv
// FP51 fast-core on-chip data memory. IRAM (0x00-0x7F), upper IRAM
// (0x80-0xFF indirect) and XRAM (0x100 up) share one array indexed directly
// by address; direct 0x80-0xFF goes to the SFR block. At most one read and one
// write reach the array per cycle because the DMA is only granted on the port
// the core leaves idle (or in the forced-stall cycle, when the core is ignored).
module fast_core_onchip_data_mem #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int XRAM_DEPTH   = 1024,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  fast_core_onchip_data_mem_if.slave bus
);
  localparam int MEM_DEPTH = 256 + XRAM_DEPTH;
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_TOP    = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [7:0]          STARVE_MAX = 8'(STARVE_LIMIT);

  localparam logic [1:0] TGT_MEM = 2'd0;
  localparam logic [1:0] TGT_SFR = 2'd1;
  localparam logic [1:0] TGT_OOR = 2'd2;

  // Classify an address: array, SFR window (direct only) or out of range.
  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic indirect);
    logic [1:0] tgt;
    if ({1'b0, addr} >= MEM_TOP) begin
      tgt = TGT_OOR;
    end else if (!indirect && (addr[ADDR_WIDTH-1:8] == '0) && addr[7]) begin
      tgt = TGT_SFR;
    end else begin
      tgt = TGT_MEM;
    end
    return tgt;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [7:0]            starve_cnt;
  logic                  stall, live;
  logic [1:0]            rd_tgt, wr_tgt, dma_tgt;
  logic                  core_rd, core_wr, dma_gnt;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx, mem_ridx;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
  logic                  rd_act, rd_is_dma;
  logic [1:0]            rd_sel_tgt;
  logic                  err_set, addr_err_q;
  logic                  v1, dma1, sfr1;
  logic [DATA_WIDTH-1:0] d1, s1_data;
  logic                  out_v, out_dma;
  logic [DATA_WIDTH-1:0] out_d;

  assign live    = ~reset;
  assign stall   = (starve_cnt == STARVE_MAX);
  assign rd_tgt  = decode(bus.rd_addr, bus.rd_indirect);
  assign wr_tgt  = decode(bus.wr_addr, bus.wr_indirect);
  assign dma_tgt = decode(bus.dma_addr, 1'b1);
  assign core_rd = live & bus.rd_en & ~stall;
  assign core_wr = live & bus.wr_en & ~stall;
  assign dma_gnt = live & bus.dma_req & (stall | (bus.dma_we ? ~bus.wr_en : ~bus.rd_en));

  // Select the single array write of this cycle (core first, then DMA).
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (core_wr && (wr_tgt == TGT_MEM)) begin
      mem_we    = 1'b1;
      mem_widx  = bus.wr_addr[IDX_W-1:0];
      mem_wdata = bus.wr_data;
    end else if (dma_gnt && bus.dma_we && (dma_tgt == TGT_MEM)) begin
      mem_we    = 1'b1;
      mem_widx  = bus.dma_addr[IDX_W-1:0];
      mem_wdata = bus.dma_wdata;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Select the single read of this cycle and form its write-first value.
  always_comb begin
    rd_act     = 1'b0;
    rd_is_dma  = 1'b0;
    rd_sel_tgt = TGT_MEM;
    mem_ridx   = '0;
    rd_word    = '0;
    if (core_rd) begin
      rd_act     = 1'b1;
      rd_sel_tgt = rd_tgt;
      mem_ridx   = bus.rd_addr[IDX_W-1:0];
    end else if (dma_gnt && !bus.dma_we) begin
      rd_act     = 1'b1;
      rd_is_dma  = 1'b1;
      rd_sel_tgt = dma_tgt;
      mem_ridx   = bus.dma_addr[IDX_W-1:0];
    end else begin
      rd_act     = 1'b0;
    end
    case (rd_sel_tgt)
      TGT_OOR: rd_word = '1;
      TGT_SFR: rd_word = '0;
      TGT_MEM: begin
        if (mem_we && (mem_widx == mem_ridx)) rd_word = mem_wdata;
        else                                  rd_word = mem[mem_ridx];
      end
      default: rd_word = '1;
    endcase
  end

  assign err_set = (core_rd & (rd_tgt == TGT_OOR)) |
                   (core_wr & (wr_tgt == TGT_OOR)) |
                   (dma_gnt & (dma_tgt == TGT_OOR));

  // Array storage; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Starvation counter, sticky error flag and first read-pipeline stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
      addr_err_q <= 1'b0;
      v1         <= 1'b0;
      dma1       <= 1'b0;
      sfr1       <= 1'b0;
      d1         <= '0;
    end else begin
      if (bus.dma_req && !dma_gnt) starve_cnt <= starve_cnt + 8'd1;
      else                         starve_cnt <= 8'd0;
      addr_err_q <= err_set | (addr_err_q & ~bus.err_clr);
      v1         <= rd_act;
      dma1       <= rd_is_dma;
      sfr1       <= rd_act & (rd_sel_tgt == TGT_SFR);
      d1         <= rd_word;
    end
  end

  // SFR data arrives one cycle after sfr_rd and joins the pipeline here.
  assign s1_data = sfr1 ? bus.sfr_rdata : d1;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign out_v   = v1;
      assign out_dma = dma1;
      assign out_d   = s1_data;
    end else begin : g_latn
      logic                  pv [2:READ_LATENCY];
      logic                  pdma [2:READ_LATENCY];
      logic [DATA_WIDTH-1:0] pd [2:READ_LATENCY];

      // Extra delay stages that align results to READ_LATENCY.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 2; k <= READ_LATENCY; k++) begin
            pv[k]   <= 1'b0;
            pdma[k] <= 1'b0;
            pd[k]   <= '0;
          end
        end else begin
          pv[2]   <= v1;
          pdma[2] <= dma1;
          pd[2]   <= s1_data;
          for (int k = 3; k <= READ_LATENCY; k++) begin
            pv[k]   <= pv[k-1];
            pdma[k] <= pdma[k-1];
            pd[k]   <= pd[k-1];
          end
        end
      end

      assign out_v   = pv[READ_LATENCY];
      assign out_dma = pdma[READ_LATENCY];
      assign out_d   = pd[READ_LATENCY];
    end
  endgenerate

  assign bus.rd_valid   = out_v & ~out_dma;
  assign bus.rd_data    = (out_v & ~out_dma) ? out_d : '0;
  assign bus.dma_rvalid = out_v & out_dma;
  assign bus.dma_rdata  = (out_v & out_dma) ? out_d : '0;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.core_stall = stall;
  assign bus.addr_err   = addr_err_q;
  assign bus.sfr_we     = core_wr & (wr_tgt == TGT_SFR);
  assign bus.sfr_rd     = core_rd & (rd_tgt == TGT_SFR);
  assign bus.sfr_addr   = ~live ? 8'h00 :
                          (core_wr & (wr_tgt == TGT_SFR)) ? bus.wr_addr[7:0] : bus.rd_addr[7:0];
  assign bus.sfr_wdata  = (core_wr & (wr_tgt == TGT_SFR)) ? bus.wr_data : '0;
endmodule

// File: tb/tb_fast_core_onchip_data_mem.sv
// Directed bench: two instances (READ_LATENCY 1 and 3) driven with identical
// stimulus; each step checks hand-computed expectations.
module tb_fast_core_onchip_data_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        rd_en = 1'b0, rd_indirect = 1'b0, wr_en = 1'b0, wr_indirect = 1'b0;
  logic [15:0] rd_addr = 16'h0000, wr_addr = 16'h0000, dma_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00, sfr_rdata = 8'h00, dma_wdata = 8'h00;
  logic        dma_req = 1'b0, dma_we = 1'b0, err_clr = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fast_core_onchip_data_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b1 ();
  fast_core_onchip_data_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b3 ();

  assign b1.rd_en = rd_en;       assign b3.rd_en = rd_en;
  assign b1.rd_addr = rd_addr;   assign b3.rd_addr = rd_addr;
  assign b1.rd_indirect = rd_indirect; assign b3.rd_indirect = rd_indirect;
  assign b1.wr_en = wr_en;       assign b3.wr_en = wr_en;
  assign b1.wr_addr = wr_addr;   assign b3.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;   assign b3.wr_data = wr_data;
  assign b1.wr_indirect = wr_indirect; assign b3.wr_indirect = wr_indirect;
  assign b1.sfr_rdata = sfr_rdata; assign b3.sfr_rdata = sfr_rdata;
  assign b1.dma_req = dma_req;   assign b3.dma_req = dma_req;
  assign b1.dma_we = dma_we;     assign b3.dma_we = dma_we;
  assign b1.dma_addr = dma_addr; assign b3.dma_addr = dma_addr;
  assign b1.dma_wdata = dma_wdata; assign b3.dma_wdata = dma_wdata;
  assign b1.err_clr = err_clr;   assign b3.err_clr = err_clr;

  fast_core_onchip_data_mem #(.READ_LATENCY(1), .STARVE_LIMIT(8)) dut_l1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  fast_core_onchip_data_mem #(.READ_LATENCY(3), .STARVE_LIMIT(8)) dut_l3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; rd_indirect = 1'b0; wr_indirect = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_l1_rvalid", b1.rd_valid, 0);
    chk("rst_l1_rdata", b1.rd_data, 0);
    chk("rst_stall", b1.core_stall, 0);
    chk("rst_err", b1.addr_err, 0);
    chk("rst_gnt", b1.dma_gnt, 0);
    reset = 1'b0;
    tick();

    // Same-cycle write/read bypass, later write does not disturb result
    rd_en = 1'b1; rd_addr = 16'h0030; wr_en = 1'b1; wr_addr = 16'h0030; wr_data = 8'h5A;
    tick();
    chk("byp_l1_valid", b1.rd_valid, 1);
    chk("byp_l1_data", b1.rd_data, 8'h5A);
    chk("byp_l3_early", b3.rd_valid, 0);
    rd_en = 1'b0; wr_data = 8'h11;
    tick();
    chk("byp_l1_once", b1.rd_valid, 0);
    chk("byp_l3_early2", b3.rd_valid, 0);
    wr_en = 1'b0;
    tick();
    chk("byp_l3_valid", b3.rd_valid, 1);
    chk("byp_l3_data", b3.rd_data, 8'h5A);
    rd_en = 1'b1;
    tick();
    chk("late_l1_data", b1.rd_data, 8'h11);
    rd_en = 1'b0;
    tick(); tick();
    chk("late_l3_data", b3.rd_data, 8'h11);

    // SFR window versus upper IRAM
    wr_en = 1'b1; wr_indirect = 1'b0; wr_addr = 16'h0090; wr_data = 8'h22;
    #1;
    chk("sfr_we_direct", b1.sfr_we, 1);
    chk("sfr_addr_wr", b1.sfr_addr, 8'h90);
    chk("sfr_wdata", b1.sfr_wdata, 8'h22);
    tick();
    wr_indirect = 1'b1; wr_data = 8'h33;
    #1;
    chk("sfr_we_indirect", b1.sfr_we, 0);
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_indirect = 1'b1; rd_addr = 16'h0090;
    tick();
    chk("uiram_l1_data", b1.rd_data, 8'h33);
    rd_indirect = 1'b0;
    #1;
    chk("sfr_rd", b1.sfr_rd, 1);
    chk("sfr_addr_rd", b1.sfr_addr, 8'h90);
    tick();
    rd_en = 1'b0; sfr_rdata = 8'h44;
    #1;
    chk("sfr_l1_valid", b1.rd_valid, 1);
    chk("sfr_l1_data", b1.rd_data, 8'h44);
    tick();
    chk("uiram_l3_data", b3.rd_data, 8'h33);
    tick();
    chk("sfr_l3_data", b3.rd_data, 8'h44);
    sfr_rdata = 8'h00;

    // XRAM top, out of range and sticky error
    idle();
    wr_en = 1'b1; wr_addr = 16'h04FF; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 16'h04FF;
    tick();
    chk("xram_top", b1.rd_data, 8'hA5);
    chk("xram_no_err", b1.addr_err, 0);
    rd_addr = 16'h0500;
    tick();
    chk("oor_valid", b1.rd_valid, 1);
    chk("oor_data", b1.rd_data, 8'hFF);
    chk("oor_err_set", b1.addr_err, 1);
    rd_en = 1'b0; err_clr = 1'b1;
    tick();
    chk("err_clr", b1.addr_err, 0);
    rd_en = 1'b1;
    tick();
    chk("err_set_wins", b1.addr_err, 1);
    rd_en = 1'b0;
    tick();
    chk("err_clr2", b1.addr_err, 0);
    err_clr = 1'b0;

    // Starvation relief
    idle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0210; dma_wdata = 8'hEE;
    rd_en = 1'b1; rd_addr = 16'h0030; wr_en = 1'b1; wr_addr = 16'h0031; wr_data = 8'h99;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("starve_gnt0", b1.dma_gnt, 0);
      chk("starve_stall0", b1.core_stall, 0);
      tick();
    end
    wr_addr = 16'h0030; wr_data = 8'hCC;
    #1;
    chk("starve_stall", b1.core_stall, 1);
    chk("starve_gnt", b1.dma_gnt, 1);
    chk("starve_stall_l3", b3.core_stall, 1);
    tick();
    chk("stall_no_rvalid", b1.rd_valid, 0);
    chk("stall_released", b1.core_stall, 0);
    dma_req = 1'b0; wr_en = 1'b0; rd_addr = 16'h0030;
    tick();
    chk("stall_no_write", b1.rd_data, 8'h11);
    rd_addr = 16'h0210;
    tick();
    chk("stall_dma_wrote", b1.rd_data, 8'hEE);

    // DMA write arbitration and same-cycle forwarding
    idle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h77;
    wr_en = 1'b1; wr_addr = 16'h0040; wr_data = 8'h12;
    #1;
    chk("dma_wr_blocked", b1.dma_gnt, 0);
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 16'h0200;
    #1;
    chk("dma_wr_gnt", b1.dma_gnt, 1);
    tick();
    dma_req = 1'b0; rd_en = 1'b0;
    chk("dma_fwd_l1", b1.rd_data, 8'h77);
    tick(); tick();
    chk("dma_fwd_l3", b3.rd_data, 8'h77);
    dma_req = 1'b1; dma_we = 1'b0;
    #1;
    chk("dma_rd_gnt", b1.dma_gnt, 1);
    tick();
    dma_req = 1'b0;
    chk("dma_rvalid", b1.dma_rvalid, 1);
    chk("dma_rdata", b1.dma_rdata, 8'h77);
    chk("dma_rd_not_core", b1.rd_valid, 0);

    // Reset with reads in flight
    idle();
    rd_en = 1'b1; rd_addr = 16'h0030;
    tick();
    rd_addr = 16'h0500;
    tick();
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_kill_valid", b3.rd_valid, 0);
    chk("rst_kill_err", b3.addr_err, 0);
    chk("rst_kill_stall", b3.core_stall, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_valid", b3.rd_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
